// File: rtl/dice_pkg.sv
// Shared types and constants for the multi-die roller: die types, face counts,
// rejection-sampling mask widths, LFSR polynomial and FSM state encoding.
package dice_pkg;

   typedef enum logic [2:0] {
      D2   = 3'd0,
      D4   = 3'd1,
      D6   = 3'd2,
      D8   = 3'd3,
      D10  = 3'd4,
      D12  = 3'd5,
      D20  = 3'd6,
      D100 = 3'd7
   } die_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ROLL = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   // Faces per die type
   localparam logic [6:0] DIE_FACES [8] = '{7'd2, 7'd4, 7'd6, 7'd8,
                                            7'd10, 7'd12, 7'd20, 7'd100};

   // Smallest bit width that covers 0..S-1, so rejection rate stays below 50%
   localparam logic [2:0] DIE_BITS [8] = '{3'd1, 3'd2, 3'd3, 3'd3,
                                           3'd4, 3'd4, 3'd5, 3'd7};

   function automatic logic [6:0] die_mask(input logic [2:0] bits);
      return 7'h7F >> (3'd7 - bits);
   endfunction

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

endpackage

// File: rtl/dice_lfsr.sv
// 32-bit Galois LFSR with step enable, reset seed and a load port.
// A load value of zero would lock the LFSR, so it is replaced by the seed.
module dice_lfsr
   import dice_pkg::*;
#(
   parameter logic [31:0] SEED = 32'hACE1_2468
)
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        i_en,
   input  logic        i_load,
   input  logic [31:0] i_load_value,
   output logic [6:0]  o_bits
);

   logic [31:0] r_state;
   logic [31:0] w_load_value;

   assign w_load_value = (i_load_value == 32'd0) ? SEED : i_load_value;

   // State register: load wins over stepping
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= SEED;
      end else if (i_load) begin
         r_state <= w_load_value;
      end else if (i_en) begin
         r_state <= lfsr_step(r_state);
      end
   end

   assign o_bits = r_state[6:0];

endmodule

// File: rtl/dice_roller_multi.sv
// Multi-die roller: rolls 1..NUM_DICE_MAX dice of one type per request and
// returns the sum and the largest face over a valid/ready handshake.
// Optional build macro DICE_SEED_LOAD_EN adds seed_load/seed_value ports that
// reseed the LFSR in any state.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | req_ready high, waiting for req_valid
// ROLL    | one LFSR draw per cycle, rejected draws retried
// DONE    | res_valid high, result held until res_ready
module dice_roller_multi
   import dice_pkg::*;
#(
   parameter int unsigned NUM_DICE_MAX = 8,
   parameter int unsigned SUM_W        = 10,
   parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468
)
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_die,
   input  logic [3:0]       req_count,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SUM_W-1:0] res_sum,
   output logic [6:0]       res_max,
   output logic             busy
`ifdef DICE_SEED_LOAD_EN
   ,
   input  logic             seed_load,
   input  logic [31:0]      seed_value
`endif
);

   localparam logic [3:0] MAX_COUNT = 4'(NUM_DICE_MAX);

   state_e           r_state;
   state_e           w_state_nxt;
   die_e             r_die;
   logic [3:0]       r_left;
   logic [SUM_W-1:0] r_sum;
   logic [6:0]       r_max;

   logic [6:0]       w_lfsr_bits;
   logic [6:0]       w_raw;
   logic [6:0]       w_face;
   logic             w_accept;
   logic [3:0]       w_count_eff;
   logic             w_seed_load;
   logic [31:0]      w_seed_value;

`ifdef DICE_SEED_LOAD_EN
   assign w_seed_load  = seed_load;
   assign w_seed_value = seed_value;
`else
   assign w_seed_load  = 1'b0;
   assign w_seed_value = 32'd0;
`endif

   dice_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_en         (1'b1),
      .i_load       (w_seed_load),
      .i_load_value (w_seed_value),
      .o_bits       (w_lfsr_bits)
   );

   assign w_raw    = w_lfsr_bits & die_mask(DIE_BITS[r_die]);
   assign w_face   = w_raw + 7'd1;
   assign w_accept = (w_raw < DIE_FACES[r_die]);

   assign w_count_eff = (req_count == 4'd0)     ? 4'd1      :
                        (req_count > MAX_COUNT) ? MAX_COUNT : req_count;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (req_valid) w_state_nxt = ST_ROLL;
         ST_ROLL: if (w_accept && (r_left == 4'd1)) w_state_nxt = ST_DONE;
         ST_DONE: if (res_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Request latch and accumulators; rejected draws leave everything unchanged
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_die  <= D2;
         r_left <= 4'd0;
         r_sum  <= '0;
         r_max  <= 7'd0;
      end else if ((r_state == ST_IDLE) && req_valid) begin
         r_die  <= die_e'(req_die);
         r_left <= w_count_eff;
         r_sum  <= '0;
         r_max  <= 7'd0;
      end else if ((r_state == ST_ROLL) && w_accept) begin
         r_left <= r_left - 4'd1;
         r_sum  <= r_sum + SUM_W'(w_face);
         if (w_face > r_max) begin
            r_max <= w_face;
         end
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign res_valid = (r_state == ST_DONE);
   assign busy      = (r_state != ST_IDLE);
   assign res_sum   = r_sum;
   assign res_max   = r_max;

endmodule

// File: tb/tb_dice_roller_multi.sv
// Bench for dice_roller_multi: table of directed requests, hand-written
// reset-abort / DONE-hold / reseed sequences, and randomized requests checked
// against a reference model that replays the LFSR and applies the dice rules.
module tb_dice_roller_multi;

   localparam int          NMAX    = 8;
   localparam int          SUMW    = 10;
   localparam logic [31:0] SEED_TB = 32'hACE1_2468;

   logic            clock;
   logic            reset_n;
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_die;
   logic [3:0]      req_count;
   logic            res_valid;
   logic            res_ready;
   logic [SUMW-1:0] res_sum;
   logic [6:0]      res_max;
   logic            busy;
`ifdef DICE_SEED_LOAD_EN
   logic            seed_load;
   logic [31:0]     seed_value;
`endif

   int n_checks = 0;
   int n_errors = 0;

   int faces_tb [8] = '{2, 4, 6, 8, 10, 12, 20, 100};
   int range_tb [8] = '{2, 4, 8, 8, 16, 16, 32, 128};
   int taps_tb  [4] = '{32, 22, 2, 1};

   logic [31:0] m_lfsr;

   dice_roller_multi dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_die   (req_die),
      .req_count (req_count),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_max   (res_max),
      .busy      (busy)
`ifdef DICE_SEED_LOAD_EN
      ,
      .seed_load (seed_load),
      .seed_value(seed_value)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Galois step for x^32+x^22+x^2+x+1, tap mask built from the exponents
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      logic [31:0] mask;
      logic [31:0] r;
      mask = 32'd0;
      foreach (taps_tb[k]) mask = mask | (32'd1 << (taps_tb[k] - 1));
      r = s >> 1;
      if (s[0]) r = r ^ mask;
      return r;
   endfunction

   // Reference copy of the free-running LFSR
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) m_lfsr = SEED_TB;
`ifdef DICE_SEED_LOAD_EN
      else if (seed_load) m_lfsr = (seed_value == 32'd0) ? SEED_TB : seed_value;
`endif
      else m_lfsr = lfsr_next(m_lfsr);
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected outcome of a request accepted while the LFSR holds v
   task automatic predict(input logic [31:0] v, input int die, input int cnt,
                          output int s, output int mx, output int cyc);
      int n, raw;
      logic [31:0] l;
      n   = (cnt == 0) ? 1 : ((cnt > NMAX) ? NMAX : cnt);
      s   = 0;
      mx  = 0;
      cyc = 1;
      l   = v;
      while (n > 0) begin
         l   = lfsr_next(l);
         cyc = cyc + 1;
         raw = int'(l[6:0]) % range_tb[die];
         if (raw < faces_tb[die]) begin
            s = s + raw + 1;
            if (raw + 1 > mx) mx = raw + 1;
            n = n - 1;
         end
      end
   endtask

   // One request; hold=1 leaves the DUT in DONE with res_ready low
   task automatic do_roll(input int die, input int cnt, input bit hold,
                          output int o_sum, output int o_max, output int o_cyc);
      int es, em, ec, n;
      @(negedge clock);
      req_valid = 1'b1;
      req_die   = 3'(die);
      req_count = 4'(cnt);
      res_ready = hold ? 1'b0 : 1'b1;
      check("req_ready_idle", req_ready, 1);
      predict(m_lfsr, die, cnt, es, em, ec);
      @(posedge clock); #1;
      req_valid = 1'b0;
      req_die   = 3'($urandom);
      req_count = 4'($urandom);
      n = 1;
      while (!res_valid && n < 400) begin
         @(posedge clock); #1;
         n++;
      end
      check("res_valid_timeout", res_valid, 1);
      check("latency", n, ec);
      check("res_sum_model", res_sum, es);
      check("res_max_model", res_max, em);
      o_sum = int'(res_sum);
      o_max = int'(res_max);
      o_cyc = n;
      if (!hold) begin
         @(posedge clock); #1;
         check("res_valid_drop", res_valid, 0);
         check("req_ready_back", req_ready, 1);
         res_ready = 1'b0;
      end
   endtask

   // Caller is at a negedge (or before any clock); release lands on a negedge
   task automatic reset_seq();
      reset_n   = 1'b0;
      req_valid = 1'b0;
      res_ready = 1'b0;
      #1;
      check("rst_res_valid", res_valid, 0);
      check("rst_res_sum", res_sum, 0);
      check("rst_res_max", res_max, 0);
      check("rst_busy", busy, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("rst_req_ready", req_ready, 1);
   endtask

   typedef struct {
      int die;
      int cnt;
      int exp_n;
      bit pow2;
   } vec_t;

   initial begin
      vec_t vecs [8];
      int s, m, c, s1, m1, s2, m2, hs, hm, d, cn;

      vecs[0] = '{3, 4,  4, 1'b1};
      vecs[1] = '{1, 0,  1, 1'b1};
      vecs[2] = '{7, 15, 8, 1'b0};
      vecs[3] = '{0, 1,  1, 1'b1};
      vecs[4] = '{2, 5,  5, 1'b0};
      vecs[5] = '{6, 8,  8, 1'b0};
      vecs[6] = '{5, 9,  8, 1'b0};
      vecs[7] = '{4, 3,  3, 1'b0};

      reset_n   = 1'b1;
      req_valid = 1'b0;
      req_die   = 3'd0;
      req_count = 4'd0;
      res_ready = 1'b0;
`ifdef DICE_SEED_LOAD_EN
      seed_load  = 1'b0;
      seed_value = 32'd0;
`endif
      #2;
      reset_seq();

      // first request after reset, reference for the abort case
      do_roll(2, 5, 1'b0, s1, m1, c);

      foreach (vecs[i]) begin
         do_roll(vecs[i].die, vecs[i].cnt, 1'b0, s, m, c);
         check("sum_range", (s >= vecs[i].exp_n) && (s <= vecs[i].exp_n * faces_tb[vecs[i].die]), 1);
         check("max_range", (m >= 1) && (m <= faces_tb[vecs[i].die]), 1);
         check("max_le_sum", m <= s, 1);
         if (vecs[i].exp_n == 1) check("single_sum_eq_max", s, m);
         if (vecs[i].pow2) check("pow2_latency", c, vecs[i].exp_n + 1);
      end

      // reset while rolling, then the first request must replay the sequence
      @(negedge clock);
      req_valid = 1'b1; req_die = 3'd2; req_count = 4'd5;
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      check("abort_busy_before", busy, 1);
      reset_seq();
      do_roll(2, 5, 1'b0, s2, m2, c);
      check("replay_sum", s2, s1);
      check("replay_max", m2, m1);

      // DONE hold: requests ignored, result stable
      do_roll(6, 6, 1'b1, hs, hm, c);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         req_valid = (i % 2 == 0);
         req_die   = 3'd7;
         req_count = 4'd8;
         check("hold_req_ready", req_ready, 0);
         check("hold_res_valid", res_valid, 1);
         check("hold_sum", res_sum, hs);
         check("hold_max", res_max, hm);
      end
      @(negedge clock);
      req_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clock); #1;
      check("hold_release_valid", res_valid, 0);
      check("hold_release_ready", req_ready, 1);
      res_ready = 1'b0;
      @(posedge clock); #1;
      check("no_second_roll", busy, 0);

`ifdef DICE_SEED_LOAD_EN
      @(negedge clock);
      seed_load = 1'b1; seed_value = 32'h1;
      @(negedge clock);
      seed_load = 1'b0;
      do_roll(5, 3, 1'b0, s1, m1, c);
      repeat (7) @(negedge clock);
      seed_load = 1'b1; seed_value = 32'h1;
      @(negedge clock);
      seed_load = 1'b0;
      do_roll(5, 3, 1'b0, s2, m2, c);
      check("seed_sum_repeat", s2, s1);
      check("seed_max_repeat", m2, m1);
`endif

      // randomized mixed requests with random idle gaps
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clock);
         d  = $urandom_range(0, 7);
         cn = $urandom_range(0, 15);
         do_roll(d, cn, 1'b0, s, m, c);
      end

      // many maximal d100 requests: faces always within 1..100
      for (int i = 0; i < 2000; i++) begin
         do_roll(7, 15, 1'b0, s, m, c);
         check("d100_sum_range", (s >= 8) && (s <= 800), 1);
         check("d100_max_range", (m >= 1) && (m <= 100), 1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
